// File: rtl/etapa_fetch_pkg.sv
// etapa_fetch_pkg: shared constants and helpers for the instruction-fetch stage.
//   - instruction width, reset PC and bubble word defaults
//   - J-type index field slice and jump-target helper
//   - next-PC source selector
package etapa_fetch_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  localparam int unsigned JIDX_MSB = 25;
  localparam int unsigned JIDX_LSB = 0;
  localparam int unsigned JIDX_W   = JIDX_MSB - JIDX_LSB + 1;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_HOLD,
    PC_BRANCH,
    PC_JUMP
  } pc_sel_e;

  // J-type target: region bits from PC+4, index shifted to a word address.
  function automatic logic [31:0] jump_target(input logic [31:0]       pc4,
                                              input logic [JIDX_W-1:0] idx);
    return {pc4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/etapa_fetch_registro_if_id.sv
// registro_if_id: IF/ID pipeline register.
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   clr_i    synchronous clear to a bubble (wins over en_i)
//   en_i     load enable (deasserted while stalled)
//   instr_i / pc4_i / valid_i   next contents
//   instr_o / pc4_o / valid_o   registered contents
module registro_if_id
  import etapa_fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] CLR_INSTR = DEF_NOP_WORD
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc4_i,
  input  logic               valid_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc4_q;
  logic               valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      instr_q <= CLR_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= valid_i;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/etapa_fetch.sv
// etapa_fetch: instruction-fetch stage of the single-issue pipeline.
//   clk, reset (sync, active-high)
//   stall, flush                hazard controls
//   branch_taken/branch_target  branch redirect from EX
//   jump_en/jump_index          J-type redirect
//   instr_in                    big-endian word read combinationally at pc_out
//   pc_out                      current PC / instruction memory byte address
//   if_id_instr/pc4/valid       IF/ID pipeline register
//   misalign_err, range_err     sticky error flags
//   fetch_count                 valid captures since reset
module etapa_fetch
  import etapa_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int unsigned MEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump_en,
  input  logic [JIDX_W-1:0]  jump_index,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [31:0]        pc_out,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic               range_err,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4;
  logic        misalign_q, misalign_d;
  logic        range_q, range_d;
  logic [31:0] count_q, count_d;
  pc_sel_e     pc_sel;
  logic        redirect;
  logic        ifid_clr;
  logic        capture;

  always_comb begin
    pc4      = pc_q + 32'd4;
    redirect = branch_taken | jump_en;

    pc_sel = PC_SEQ;
    if (branch_taken)  pc_sel = PC_BRANCH;
    else if (jump_en)  pc_sel = PC_JUMP;
    else if (stall)    pc_sel = PC_HOLD;

    pc_d = pc4;
    unique case (pc_sel)
      PC_SEQ:    pc_d = pc4;
      PC_HOLD:   pc_d = pc_q;
      PC_BRANCH: pc_d = {branch_target[31:2], 2'b00};
      PC_JUMP:   pc_d = jump_target(pc4, jump_index);
    endcase

    // A redirect makes the word fetched this cycle wrong-path, so it is
    // squashed exactly like an explicit flush; clear beats the stall hold.
    ifid_clr = redirect | flush;
    capture  = ~stall & ~ifid_clr;

    misalign_d = misalign_q | (branch_taken & (branch_target[1:0] != 2'b00));
    range_d    = range_q | (capture & (pc_q > LAST_WORD_ADDR));
    count_d    = capture ? count_q + 32'd1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      range_q    <= range_d;
      count_q    <= count_d;
    end
  end

  registro_if_id #(
    .CLR_INSTR (NOP_WORD)
  ) u_if_id (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (ifid_clr),
    .en_i    (~stall),
    .instr_i (instr_in),
    .pc4_i   (pc4),
    .valid_i (1'b1),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign pc_out       = pc_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_etapa_fetch.sv
module tb_etapa_fetch;

  localparam int unsigned MEMB = 256;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump_en = 1'b0;
  logic [25:0] jump_index = '0;
  logic [31:0] instr_in;
  logic [31:0] pc_out, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign_err, range_err;

  etapa_fetch #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (MEMB),
    .NOP_WORD  (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .instr_in      (instr_in),
    .pc_out        (pc_out),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err),
    .range_err     (range_err),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Byte-wide instruction memory, big-endian word read, address wraps at 256.
  logic [7:0] mem [MEMB];

  always_comb begin
    logic [7:0] a;
    a = pc_out[7:0];
    instr_in = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  end

  function automatic logic [31:0] rd(input logic [31:0] addr);
    logic [7:0] a;
    a = addr[7:0];
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic put_word(input int unsigned addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic        rng;
    logic [31:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t m = '0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Apply one cycle of inputs, predict the architectural state after the
  // edge from the stage's rules, and queue the prediction.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji);
    obs_t        n;
    logic [31:0] p4;
    @(negedge clk);
    reset = r; stall = s; flush = f;
    branch_taken = b; branch_target = bt;
    jump_en = j; jump_index = ji;
    if (r) begin
      n = '0;
    end else begin
      n  = m;
      p4 = m.pc + 32'd4;
      if (b) begin
        n.pc = bt & 32'hFFFF_FFFC;
        if (bt % 4 != 0) n.mis = 1'b1;
      end else if (j) begin
        n.pc = (p4 & 32'hF000_0000) | (32'(ji) * 4);
      end else if (!s) begin
        n.pc = p4;
      end
      if (b || j || f) begin
        n.instr = NOP; n.pc4 = '0; n.valid = 1'b0;
      end else if (!s) begin
        n.instr = rd(m.pc);
        n.pc4   = p4;
        n.valid = 1'b1;
        n.cnt   = m.cnt + 32'd1;
        if (m.pc > MEMB - 4) n.rng = 1'b1;
      end
    end
    m = n;
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    step(0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: every cycle with a queued prediction is compared against the DUT.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pc_out, if_id_instr, if_id_pc4, if_id_valid, misalign_err, range_err, fetch_count};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL scoreboard cyc %0d: got pc=%h instr=%h pc4=%h v=%b mis=%b rng=%b cnt=%0d, expected pc=%h instr=%h pc4=%h v=%b mis=%b rng=%b cnt=%0d",
                      cyc, a.pc, a.instr, a.pc4, a.valid, a.mis, a.rng, a.cnt,
                      e.pc, e.instr, e.pc4, e.valid, e.mis, e.rng, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    put_word(0, 32'h014A1820);
    put_word(4, 32'h004D5820);
    put_word(8, 32'h000D4A02);

    step(1, 0, 0, 0, '0, 0, '0);
    step(1, 1, 0, 1, 32'h55, 0, '0);
    chk("reset pc", pc_out, 32'h0);
    chk("reset count", fetch_count, 32'd0);
    chk("reset valid", 32'(if_id_valid), 32'd0);

    seq();
    chk("seq1 pc", pc_out, 32'h4);
    chk("seq1 instr", if_id_instr, 32'h014A1820);
    seq();
    chk("seq2 pc", pc_out, 32'h8);
    chk("seq2 pc4", if_id_pc4, 32'h8);

    step(0, 1, 0, 0, '0, 0, '0);
    step(0, 1, 0, 0, '0, 0, '0);
    chk("stall pc", pc_out, 32'h8);
    chk("stall instr", if_id_instr, 32'h004D5820);
    chk("stall count", fetch_count, 32'd2);

    seq();
    chk("resume pc", pc_out, 32'hC);
    chk("resume instr", if_id_instr, 32'h000D4A02);
    chk("resume pc4", if_id_pc4, 32'hC);
    chk("resume count", fetch_count, 32'd3);

    step(0, 1, 0, 1, 32'h40, 0, '0);
    chk("branch pc", pc_out, 32'h40);
    chk("branch valid", 32'(if_id_valid), 32'd0);
    chk("branch mis", 32'(misalign_err), 32'd0);

    step(0, 0, 0, 1, 32'h42, 0, '0);
    chk("misalign pc", pc_out, 32'h40);
    chk("misalign flag", 32'(misalign_err), 32'd1);
    seq(); seq();
    chk("misalign sticky", 32'(misalign_err), 32'd1);

    step(0, 0, 0, 1, 32'h10, 0, '0);
    step(0, 0, 0, 0, '0, 1, 26'h0000010);
    chk("jump pc", pc_out, 32'h40);
    step(0, 0, 0, 1, 32'h10, 0, '0);
    step(0, 0, 0, 1, 32'h20, 1, 26'h0000010);
    chk("branch over jump", pc_out, 32'h20);

    step(0, 0, 1, 0, '0, 0, '0);
    chk("flush advance pc", pc_out, 32'h24);
    chk("flush bubble", 32'(if_id_valid), 32'd0);
    step(0, 1, 1, 0, '0, 0, '0);
    chk("flush+stall pc", pc_out, 32'h24);

    step(0, 0, 0, 1, 32'hF8, 0, '0);
    seq();
    seq();
    chk("range at FC", 32'(range_err), 32'd0);
    chk("pc at 100", pc_out, 32'h100);
    seq();
    chk("range at 100", 32'(range_err), 32'd1);

    step(1, 1, 0, 1, 32'h80, 0, '0);
    chk("reset clr range", 32'(range_err), 32'd0);
    chk("reset clr mis", 32'(misalign_err), 32'd0);
    chk("reset pc2", pc_out, 32'h0);
    chk("reset count2", fetch_count, 32'd0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           32'($urandom_range(0, 511)),
           ($urandom_range(0, 9) == 0),
           26'($urandom_range(0, 127)));
    end

    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0) break;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
